// File: rtl/apb_cmd_master_if.sv
// Bundles the command/response channels and the APB requester signals of apb_cmd_master.
// The master modport is the requester's view; slave is the view of whatever sits around it.
interface apb_cmd_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Turns single valid/ready commands into one APB SETUP->ACCESS transfer each, returning
// read data and error status on a response channel, with a watchdog on PREADY wait states.
module apb_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_cmd_master_if.master    bus_io
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  localparam logic [15:0] WdogLast = 16'(TIMEOUT_CYCLES - 1);

  state_e                state_q;
  logic [15:0]           wdog_q;
  logic                  cmd_ready_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= StIdle;
      wdog_q        <= '0;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // cmd_ready_q is always high here, so cmd_valid alone marks the handshake.
          if (bus_io.cmd_valid) begin
            pwrite_q    <= bus_io.cmd_write;
            paddr_q     <= bus_io.cmd_addr;
            pwdata_q    <= bus_io.cmd_wdata;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            state_q     <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          wdog_q    <= '0;
          state_q   <= StAccess;
        end
        StAccess: begin
          // PREADY is tested first so completion wins over a simultaneous watchdog expiry.
          if (bus_io.PREADY) begin
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= bus_io.PSLVERR;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= (!pwrite_q && !bus_io.PSLVERR) ? bus_io.PRDATA : '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= StResp;
          end else if (wdog_q == WdogLast) begin
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= StResp;
          end else begin
            wdog_q <= wdog_q + 16'd1;
          end
        end
        StResp: begin
          if (bus_io.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.cmd_ready   = cmd_ready_q;
  assign bus_io.rsp_valid   = rsp_valid_q;
  assign bus_io.rsp_rdata   = rsp_rdata_q;
  assign bus_io.rsp_err     = rsp_err_q;
  assign bus_io.rsp_timeout = rsp_timeout_q;
  assign bus_io.PSEL        = psel_q;
  assign bus_io.PENABLE     = penable_q;
  assign bus_io.PWRITE      = pwrite_q;
  assign bus_io.PADDR       = paddr_q;
  assign bus_io.PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master against a 1024-deep slave model holding MEM[i] = i,
// with configurable wait states and a PREADY-stuck-low mode.
module tb_apb_cmd_master;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   slv_wait;
  logic slv_hang;
  logic [15:0] acc_cnt;

  apb_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_cmd_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK   (clk),
    .PRESETn(rst_n),
    .bus_io (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave: counts ACCESS cycles and raises PREADY once slv_wait wait states have elapsed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_cnt <= '0;
    else if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 16'd1;
    else acc_cnt <= '0;
  end

  assign bus.PREADY  = bus.PSEL && bus.PENABLE && !slv_hang && (int'(acc_cnt) >= slv_wait);
  assign bus.PSLVERR = bus.PREADY && (bus.PADDR >= 32'd1024);
  assign bus.PRDATA  = (bus.PADDR < 32'd1024) ? bus.PADDR : 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one command, waits for acceptance, then follows the bus until rsp_valid.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int psel_n, output int pen_n, output int lat,
                         output logic stable);
    int guard;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin
      step();
      guard++;
    end
    step();
    bus.cmd_valid = 1'b0;
    psel_n = 0;
    pen_n  = 0;
    lat    = 1;
    stable = 1'b1;
    while (!bus.rsp_valid && lat < 60) begin
      if (bus.PSEL) psel_n++;
      if (bus.PENABLE) pen_n++;
      if (bus.PSEL && (bus.PWDATA !== d || bus.PADDR !== a || bus.PWRITE !== w)) stable = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic rsp_ack(input string tag);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check({tag, "_ack_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_ack_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    int   psel_n;
    int   pen_n;
    int   lat;
    logic stable;
    int   guard;

    errors = 0;
    checks = 0;
    slv_wait = 0;
    slv_hang = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();

    check("rst_cmd_ready",   32'(bus.cmd_ready),   32'd1);
    check("rst_psel",        32'(bus.PSEL),        32'd0);
    check("rst_penable",     32'(bus.PENABLE),     32'd0);
    check("rst_rsp_valid",   32'(bus.rsp_valid),   32'd0);
    check("rst_rsp_err",     32'(bus.rsp_err),     32'd0);
    check("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("rst_paddr",       bus.PADDR,            32'd0);
    check("rst_pwdata",      bus.PWDATA,           32'd0);
    rst_n = 1'b1;
    step();

    // Write with one slave wait state.
    slv_wait = 1;
    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, psel_n, pen_n, lat, stable);
    check("wr_psel_cycles", 32'(psel_n), 32'd3);
    check("wr_pen_cycles",  32'(pen_n),  32'd2);
    check("wr_stable",      32'(stable), 32'd1);
    check("wr_latency",     32'(lat),    32'd4);
    check("wr_rsp_valid",   32'(bus.rsp_valid), 32'd1);
    check("wr_rsp_err",     32'(bus.rsp_err),   32'd0);
    check("wr_rsp_rdata",   bus.rsp_rdata,      32'd0);
    check("wr_psel_done",   32'(bus.PSEL),      32'd0);
    rsp_ack("wr");
    check("wr_paddr_kept",  bus.PADDR,  32'h0000_0010);
    check("wr_pwdata_kept", bus.PWDATA, 32'hDEAD_BEEF);

    // Zero-wait reads, back to back.
    slv_wait = 0;
    run_txn(1'b0, 32'h0000_0005, 32'h0, psel_n, pen_n, lat, stable);
    check("rd5_latency", 32'(lat),       32'd3);
    check("rd5_rdata",   bus.rsp_rdata,  32'h0000_0005);
    check("rd5_err",     32'(bus.rsp_err), 32'd0);
    rsp_ack("rd5");
    run_txn(1'b0, 32'h0000_03FF, 32'h0, psel_n, pen_n, lat, stable);
    check("rd3ff_rdata", bus.rsp_rdata,  32'h0000_03FF);
    check("rd3ff_err",   32'(bus.rsp_err), 32'd0);
    rsp_ack("rd3ff");

    // Out-of-range read: slave error.
    run_txn(1'b0, 32'h0000_0400, 32'h0, psel_n, pen_n, lat, stable);
    check("rderr_err",     32'(bus.rsp_err),     32'd1);
    check("rderr_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("rderr_rdata",   bus.rsp_rdata,        32'd0);
    rsp_ack("rderr");

    // PREADY stuck low: watchdog aborts after exactly 4 ACCESS cycles.
    slv_hang = 1'b1;
    run_txn(1'b0, 32'h0000_0006, 32'h0, psel_n, pen_n, lat, stable);
    check("to_pen_cycles", 32'(pen_n),           32'd4);
    check("to_latency",    32'(lat),             32'd6);
    check("to_psel",       32'(bus.PSEL),        32'd0);
    check("to_err",        32'(bus.rsp_err),     32'd1);
    check("to_timeout",    32'(bus.rsp_timeout), 32'd1);
    check("to_rdata",      bus.rsp_rdata,        32'd0);
    rsp_ack("to");
    slv_hang = 1'b0;

    // PREADY arrives on the last watchdog cycle: completion wins.
    slv_wait = 3;
    run_txn(1'b0, 32'h0000_0007, 32'h0, psel_n, pen_n, lat, stable);
    check("edge_pen_cycles", 32'(pen_n),           32'd4);
    check("edge_timeout",    32'(bus.rsp_timeout), 32'd0);
    check("edge_err",        32'(bus.rsp_err),     32'd0);
    check("edge_rdata",      bus.rsp_rdata,        32'h0000_0007);
    rsp_ack("edge");
    slv_wait = 0;

    // Response backpressure with a new command waiting.
    run_txn(1'b1, 32'h0000_0020, 32'h1234_5678, psel_n, pen_n, lat, stable);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_0009;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_err",   32'(bus.rsp_err),   32'd0);
      check("bp_rsp_rdata", bus.rsp_rdata,      32'd0);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("bp_psel",      32'(bus.PSEL),      32'd0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("bp_ack_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_ack_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("bp_ack_psel",      32'(bus.PSEL),      32'd0);
    step();
    bus.cmd_valid = 1'b0;
    check("bp_next_psel",  32'(bus.PSEL),      32'd1);
    check("bp_next_paddr", bus.PADDR,          32'h0000_0009);
    check("bp_next_ready", 32'(bus.cmd_ready), 32'd0);
    guard = 0;
    while (!bus.rsp_valid && guard < 20) begin
      step();
      guard++;
    end
    check("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_next_rdata", bus.rsp_rdata,      32'h0000_0009);
    rsp_ack("bp_next");

    // Reset pulsed during ACCESS.
    slv_hang = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_0011;
    step();
    bus.cmd_valid = 1'b0;
    step();
    check("mr_in_access", 32'(bus.PENABLE), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_psel",      32'(bus.PSEL),      32'd0);
    check("mr_penable",   32'(bus.PENABLE),   32'd0);
    check("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    rst_n = 1'b1;
    slv_hang = 1'b0;
    step();
    run_txn(1'b0, 32'h0000_0011, 32'h0, psel_n, pen_n, lat, stable);
    check("mr_next_latency", 32'(lat),         32'd3);
    check("mr_next_rdata",   bus.rsp_rdata,    32'h0000_0011);
    check("mr_next_err",     32'(bus.rsp_err), 32'd0);
    rsp_ack("mr_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
